mem_stage_ctrl: RTL and testbench

MEM-stage access controller of the 5-stage MIPS pipeline. It consumes the EX/MEM register outputs, performs the data-memory read or write over a req/ack handshake with variable wait states, and stalls the upstream pipeline while the access is outstanding. It loads the MEM/WB register, inserting a bubble on every stall, fault or timeout cycle.

---
 rtl/mem_stage_pkg.sv | 24 ++
 rtl/memwb_reg.sv | 54 +++++
 rtl/mem_stage_ctrl.sv | 117 +++++++++++
 tb/tb_mem_stage_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
// mem_stage_pkg : shared types and constants for the MIPS MEM-stage controller
// Revision      : 1.0
// ============================================================================
package mem_stage_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    localparam int TIMEOUT_DEFAULT = 16;
    localparam int CNT_W           = 8;

    typedef struct packed {
        logic reg_write;
        logic memtoreg;
    } wb_ctrl_t;

    localparam wb_ctrl_t WB_BUBBLE = '{reg_write: 1'b0, memtoreg: 1'b0};

endpackage
`default_nettype wire

// File: rtl/memwb_reg.sv
`default_nettype none
// ============================================================================
// memwb_reg : MEM/WB pipeline register with bubble insertion
// Revision  : 1.0
// ============================================================================
module memwb_reg
    import mem_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        bubble,
    input  logic        load_rdata,
    input  logic [4:0]  wreg_i,
    input  logic [31:0] rdata_i,
    input  logic [31:0] alu_i,
    input  wb_ctrl_t    ctrl_i,
    output logic [4:0]  wreg_o,
    output logic [31:0] rdata_o,
    output logic [31:0] alu_o,
    output wb_ctrl_t    ctrl_o
);

    logic [4:0]  wreg_q;
    logic [31:0] rdata_q;
    logic [31:0] alu_q;
    wb_ctrl_t    ctrl_q;

    // A bubble clears only the controls; the data fields keep their old values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wreg_q  <= 5'd0;
            rdata_q <= 32'd0;
            alu_q   <= 32'd0;
            ctrl_q  <= WB_BUBBLE;
        end else if (bubble) begin
            ctrl_q  <= WB_BUBBLE;
        end else if (load) begin
            wreg_q  <= wreg_i;
            alu_q   <= alu_i;
            ctrl_q  <= ctrl_i;
            if (load_rdata) begin
                rdata_q <= rdata_i;
            end
        end
    end

    assign wreg_o  = wreg_q;
    assign rdata_o = rdata_q;
    assign alu_o   = alu_q;
    assign ctrl_o  = ctrl_q;

endmodule
`default_nettype wire

// File: rtl/mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
// mem_stage_ctrl : MEM-stage data-memory access controller with stall/timeout
// Revision       : 1.0
// ============================================================================
module mem_stage_ctrl
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  writeRegMEM,
    input  logic [31:0] data_addr,
    input  logic [31:0] writeData,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        RegWriteMem,
    input  logic        memtoregMEM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        stall,
    output logic [4:0]  writeRegWB,
    output logic [31:0] readDataWB,
    output logic [31:0] aluResultWB,
    output logic        RegWriteWB,
    output logic        memtoregWB,
    output logic        mem_fault,
    output logic        bus_err
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mem_fault_q, bus_err_q;

    logic access, illegal, in_wait, timeout;
    wb_ctrl_t ctrl_in, ctrl_out;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mem_fault_q <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_fault_q <= illegal;
            bus_err_q   <= timeout;
        end
    end

    // Gating with reset keeps req/stall low even while an access sits on the inputs.
    always_comb begin
        access   = mem_read ^ mem_write;
        illegal  = (mem_read & mem_write) | (access & (data_addr[1:0] != 2'b00));
        in_wait  = (state_q == WAIT);
        timeout  = in_wait & ~dmem_ack & (cnt_q == CNT_W'(TIMEOUT - 1));
        dmem_req = ~reset & (in_wait | (access & ~illegal));
        stall    = dmem_req & ~dmem_ack & ~timeout;
        state_d  = state_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (dmem_req && !dmem_ack) begin
                    state_d = WAIT;
                    cnt_d   = CNT_W'(1);
                end
            end
            WAIT: begin
                if (dmem_ack || timeout) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign dmem_we    = mem_write;
    assign dmem_addr  = data_addr;
    assign dmem_wdata = writeData;

    assign ctrl_in = '{reg_write: RegWriteMem, memtoreg: memtoregMEM};

    memwb_reg u_memwb (
        .clk        (clk),
        .reset      (reset),
        .load       (~stall),
        .bubble     (stall | illegal | timeout),
        .load_rdata (dmem_req & dmem_ack & mem_read),
        .wreg_i     (writeRegMEM),
        .rdata_i    (dmem_rdata),
        .alu_i      (data_addr),
        .ctrl_i     (ctrl_in),
        .wreg_o     (writeRegWB),
        .rdata_o    (readDataWB),
        .alu_o      (aluResultWB),
        .ctrl_o     (ctrl_out)
    );

    assign RegWriteWB = ctrl_out.reg_write;
    assign memtoregWB = ctrl_out.memtoreg;
    assign mem_fault  = mem_fault_q;
    assign bus_err    = bus_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
// tb_mem_stage_ctrl : directed + randomized bench with a behavioural MEM model
// Revision          : 1.0
// ============================================================================
module tb_mem_stage_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  writeRegMEM = '0;
    logic [31:0] data_addr = '0, writeData = '0, dmem_rdata = '0;
    logic        mem_read = 1'b0, mem_write = 1'b0, RegWriteMem = 1'b0, memtoregMEM = 1'b0;
    logic        dmem_ack = 1'b0;
    logic        dmem_req, dmem_we, stall, RegWriteWB, memtoregWB, mem_fault, bus_err;
    logic [31:0] dmem_addr, dmem_wdata, readDataWB, aluResultWB;
    logic [4:0]  writeRegWB;

    mem_stage_ctrl #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .writeRegMEM(writeRegMEM), .data_addr(data_addr),
        .writeData(writeData), .mem_read(mem_read), .mem_write(mem_write),
        .RegWriteMem(RegWriteMem), .memtoregMEM(memtoregMEM), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .stall(stall),
        .writeRegWB(writeRegWB), .readDataWB(readDataWB), .aluResultWB(aluResultWB),
        .RegWriteWB(RegWriteWB), .memtoregWB(memtoregWB), .mem_fault(mem_fault),
        .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: request cycles spent on the current instruction plus the MEM/WB contents.
    int          elapsed = 0;
    logic        last_stall = 1'b0;
    logic [4:0]  m_wreg = '0;
    logic [31:0] m_rdata = '0, m_alu = '0;
    logic        m_rw = 1'b0, m_m2r = 1'b0, m_fault = 1'b0, m_berr = 1'b0;

    function automatic void predict(output logic req, output logic stl,
                                    output logic tmo, output logic ill);
        logic acc;
        acc = mem_read ^ mem_write;
        ill = (mem_read & mem_write) | (acc & (data_addr[1:0] != 2'b00));
        req = !reset && (elapsed > 0 || (acc && !ill));
        tmo = !reset && elapsed > 0 && !dmem_ack && (elapsed + 1 == TO);
        stl = req && !dmem_ack && !tmo;
    endfunction

    always @(posedge clk or posedge reset) begin
        logic req, stl, tmo, ill;
        if (reset) begin
            elapsed = 0; last_stall = 0;
            m_wreg = 0; m_rdata = 0; m_alu = 0; m_rw = 0; m_m2r = 0; m_fault = 0; m_berr = 0;
        end else begin
            predict(req, stl, tmo, ill);
            m_fault = ill;
            m_berr  = tmo;
            if (stl || ill || tmo) begin
                m_rw = 0; m_m2r = 0;
            end else begin
                m_wreg = writeRegMEM; m_alu = data_addr; m_rw = RegWriteMem; m_m2r = memtoregMEM;
                if (req && dmem_ack && mem_read) m_rdata = dmem_rdata;
            end
            elapsed    = stl ? elapsed + 1 : 0;
            last_stall = stl;
        end
    end

    always @(negedge clk) begin
        logic req, stl, tmo, ill;
        predict(req, stl, tmo, ill);
        chk("dmem_req", {31'd0, dmem_req}, {31'd0, req});
        chk("stall", {31'd0, stall}, {31'd0, stl});
        if (req) chk("dmem_we", {31'd0, dmem_we}, {31'd0, mem_write});
        chk("dmem_addr", dmem_addr, data_addr);
        chk("dmem_wdata", dmem_wdata, writeData);
        chk("writeRegWB", {27'd0, writeRegWB}, {27'd0, m_wreg});
        chk("readDataWB", readDataWB, m_rdata);
        chk("aluResultWB", aluResultWB, m_alu);
        chk("RegWriteWB", {31'd0, RegWriteWB}, {31'd0, m_rw});
        chk("memtoregWB", {31'd0, memtoregWB}, {31'd0, m_m2r});
        chk("mem_fault", {31'd0, mem_fault}, {31'd0, m_fault});
        chk("bus_err", {31'd0, bus_err}, {31'd0, m_berr});
    end

    task automatic setin(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [4:0] wreg,
                         input logic rw, input logic m2r);
        mem_read = rd; mem_write = wr; data_addr = addr; writeData = wd;
        writeRegMEM = wreg; RegWriteMem = rw; memtoregMEM = m2r;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_RegWriteWB", {31'd0, RegWriteWB}, 32'd0);
        chk("rst_readDataWB", readDataWB, 32'd0);
        chk("rst_aluResultWB", aluResultWB, 32'd0);
        chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
        reset = 1'b0;

        // ALU pass-through
        setin(0, 0, 32'h40, 32'h0, 5'd5, 1, 0);
        #1;
        chk("alu_req", {31'd0, dmem_req}, 32'd0);
        chk("alu_stall", {31'd0, stall}, 32'd0);
        step();
        chk("alu_result", aluResultWB, 32'h40);
        chk("alu_wreg", {27'd0, writeRegWB}, 32'd5);
        chk("alu_regwrite", {31'd0, RegWriteWB}, 32'd1);

        // Load with ack three cycles after the first request
        setin(1, 0, 32'h100, 32'h0, 5'd7, 1, 1);
        repeat (3) begin
            #1 chk("ld_stall", {31'd0, stall}, 32'd1);
            step();
            chk("ld_bubble", {31'd0, RegWriteWB}, 32'd0);
        end
        dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
        #1 chk("ld_ack_stall", {31'd0, stall}, 32'd0);
        step();
        dmem_ack = 1'b0;
        chk("ld_rdata", readDataWB, 32'hDEAD_BEEF);
        chk("ld_m2r", {31'd0, memtoregWB}, 32'd1);

        // Zero-wait store
        setin(0, 1, 32'h200, 32'h1234_5678, 5'd3, 0, 0);
        dmem_ack = 1'b1;
        #1;
        chk("st_we", {31'd0, dmem_we}, 32'd1);
        chk("st_stall", {31'd0, stall}, 32'd0);
        step();
        dmem_ack = 1'b0;
        setin(0, 0, 32'h44, 32'h0, 5'd0, 0, 0);
        #1;
        chk("st_we_drop", {31'd0, dmem_we}, 32'd0);
        chk("st_rdata_hold", readDataWB, 32'hDEAD_BEEF);

        // Misaligned load, then read+write together
        setin(1, 0, 32'h103, 32'h0, 5'd9, 1, 1);
        #1 chk("mis_req", {31'd0, dmem_req}, 32'd0);
        step();
        chk("mis_fault", {31'd0, mem_fault}, 32'd1);
        chk("mis_bubble", {31'd0, RegWriteWB}, 32'd0);
        setin(1, 1, 32'h100, 32'h0, 5'd9, 1, 1);
        #1 chk("rw_stall", {31'd0, stall}, 32'd0);
        step();
        chk("rw_fault", {31'd0, mem_fault}, 32'd1);
        setin(0, 0, 32'h0, 32'h0, 5'd0, 0, 0);
        step();
        chk("fault_pulse_end", {31'd0, mem_fault}, 32'd0);

        // Timeout with TIMEOUT=4, then a stray ack
        setin(1, 0, 32'h300, 32'h0, 5'd4, 1, 1);
        repeat (3) begin
            #1 chk("to_stall", {31'd0, stall}, 32'd1);
            step();
        end
        #1;
        chk("to_last_stall", {31'd0, stall}, 32'd0);
        chk("to_last_req", {31'd0, dmem_req}, 32'd1);
        step();
        chk("to_bus_err", {31'd0, bus_err}, 32'd1);
        chk("to_bubble", {31'd0, RegWriteWB}, 32'd0);
        setin(0, 0, 32'h0, 32'h0, 5'd0, 0, 0);
        dmem_ack = 1'b1; dmem_rdata = 32'hBADB_AD00;
        #1 chk("stray_req", {31'd0, dmem_req}, 32'd0);
        step();
        dmem_ack = 1'b0;
        chk("berr_pulse_end", {31'd0, bus_err}, 32'd0);
        chk("stray_rdata", readDataWB, 32'hDEAD_BEEF);

        // Reset during the second WAIT cycle
        setin(1, 0, 32'h400, 32'h0, 5'd6, 1, 1);
        step();
        step();
        reset = 1'b1;
        #1;
        chk("arst_req", {31'd0, dmem_req}, 32'd0);
        chk("arst_stall", {31'd0, stall}, 32'd0);
        chk("arst_rdata", readDataWB, 32'd0);
        @(negedge clk);
        #1 reset = 1'b0;
        dmem_ack = 1'b1; dmem_rdata = 32'hCAFE_F00D;
        #1 chk("post_rst_req", {31'd0, dmem_req}, 32'd1);
        step();
        dmem_ack = 1'b0;
        chk("post_rst_rdata", readDataWB, 32'hCAFE_F00D);
        chk("post_rst_alu", aluResultWB, 32'h400);

        // Randomized traffic; the instruction is held while the model predicts a stall
        for (int i = 0; i < 3000; i++) begin
            if (!last_stall) begin
                int unsigned kind;
                logic [31:0] a;
                kind = $urandom_range(0, 5);
                a = $urandom;
                a[1:0] = (kind == 4) ? 2'($urandom_range(1, 3)) : 2'b00;
                case (kind)
                    2:       setin(1, 0, a, $urandom, 5'($urandom), 1'($urandom), 1'($urandom));
                    3:       setin(0, 1, a, $urandom, 5'($urandom), 1'($urandom), 1'($urandom));
                    4:       setin(1'($urandom), 1'($urandom), a, $urandom, 5'($urandom), 1, 1);
                    5:       setin(1, 1, a, $urandom, 5'($urandom), 1, 1);
                    default: setin(0, 0, $urandom, $urandom, 5'($urandom), 1'($urandom), 1'($urandom));
                endcase
            end
            dmem_ack   = ($urandom_range(0, 3) == 0);
            dmem_rdata = $urandom;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
